// File: rtl/axi_write_burst.sv
// rtl/axi_write_burst.sv - AXI4 write-burst master draining a FIFO into 4 KB-safe INCR bursts
module axi_write_burst #(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    localparam int STRB_W   = DATA_W / 8,
    localparam int BYTE_SH  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       addr,
    input  logic [15:0]       transfer_size,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              empty,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {IDLE, ADDR, FETCH, DATA, RESP, FINISH} state_t;

    localparam logic [16:0] MAX_B = 17'(MAX_BURST);

    state_t              state_q, state_d;
    logic [31:0]         addr_q;
    logic [16:0]         beats_left_q;
    logic [8:0]          burst_beats_q;
    logic [8:0]          burst_rem_q;
    logic [BYTE_SH-1:0]  rem_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_pend_q;
    logic                error_q;

    logic [16:0]         to_4k;
    logic [16:0]         burst_beats;
    logic [16:0]         beats_total;
    logic [31:0]         addr_al;
    logic [STRB_W-1:0]   last_strb;

    // Burst length is bounded by what is left, the burst cap and the next 4 KB page edge.
    always_comb begin
        to_4k       = (17'd4096 - {5'd0, addr_q[11:0]}) >> BYTE_SH;
        burst_beats = beats_left_q;
        if (burst_beats > MAX_B) burst_beats = MAX_B;
        if (burst_beats > to_4k) burst_beats = to_4k;
        beats_total = ({1'b0, transfer_size} + 17'(STRB_W - 1)) >> BYTE_SH;
        addr_al     = addr & ~32'(STRB_W - 1);
        last_strb   = '0;
        for (int i = 0; i < STRB_W; i++) last_strb[i] = (i < int'(rem_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = (transfer_size == 16'd0) ? FINISH : ADDR;
            ADDR:   if (awready) state_d = FETCH;
            FETCH:  if (rd_pend_q) state_d = DATA;
            DATA:   if (wready) state_d = (burst_rem_q == 9'd1) ? RESP : FETCH;
            RESP:   if (bvalid) begin
                        if (bresp != 2'b00)            state_d = FINISH;
                        else if (beats_left_q != '0)   state_d = ADDR;
                        else                           state_d = FINISH;
                    end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awvalid = (state_q == ADDR);
        awlen   = awvalid ? 8'(burst_beats - 17'd1) : 8'd0;
        awaddr  = addr_q;
        awsize  = 3'(BYTE_SH);
        awburst = 2'b01;
        wvalid  = (state_q == DATA);
        wdata   = wdata_q;
        wlast   = wvalid && (burst_rem_q == 9'd1);
        wstrb   = '0;
        if (wvalid) wstrb = (beats_left_q == 17'd1 && rem_q != '0) ? last_strb : '1;
        rd_en   = (state_q == FETCH) && !rd_pend_q && !empty;
        bready  = (state_q == RESP);
        done    = (state_q == FINISH);
        busy    = (state_q != IDLE) && (state_q != FINISH);
        error   = error_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            beats_left_q  <= '0;
            burst_beats_q <= '0;
            burst_rem_q   <= '0;
            rem_q         <= '0;
            wdata_q       <= '0;
            rd_pend_q     <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    error_q      <= 1'b0;
                    addr_q       <= addr_al;
                    beats_left_q <= beats_total;
                    rem_q        <= transfer_size[BYTE_SH-1:0];
                end
                ADDR: if (awready) begin
                    burst_beats_q <= burst_beats[8:0];
                    burst_rem_q   <= burst_beats[8:0];
                end
                // FIFO data arrives the cycle after rd_en, so capture on the following cycle.
                FETCH: begin
                    rd_pend_q <= rd_en;
                    if (rd_pend_q) wdata_q <= data_in;
                end
                DATA: if (wready) begin
                    burst_rem_q  <= burst_rem_q - 9'd1;
                    beats_left_q <= beats_left_q - 17'd1;
                end
                RESP: if (bvalid) begin
                    if (bresp != 2'b00) error_q <= 1'b1;
                    else addr_q <= addr_q + (32'(burst_beats_q) << BYTE_SH);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/axi_write_burst.md
AXI_WRITE_BURST -- requirements
Module: axi_write_burst

Interface
REQ-001 Parameter DATA_W, default 32, meaning AXI/FIFO data width in bits; legal values 32 and 64.
REQ-002 Parameter MAX_BURST, default 16, meaning maximum beats per AXI burst; legal range 1..256.
REQ-003 Derived STRB_W = DATA_W/8 and BYTE_SH = log2(STRB_W); address width fixed at 32.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 addr  in  32  start byte address; low BYTE_SH bits treated as zero.
REQ-008 transfer_size  in  16  byte count to write.
REQ-009 awaddr, awlen, awsize, awburst, awvalid, awready: out 32, out 8, out 3, out 2, out 1, in 1; AXI4 AW channel.
REQ-010 wdata, wstrb, wlast, wvalid, wready: out DATA_W, out STRB_W, out 1, out 1, in 1; AXI4 W channel.
REQ-011 bresp, bvalid, bready: in 2, in 1, out 1; AXI4 B channel.
REQ-012 data_in, empty, rd_en: in DATA_W, in 1, out 1; FIFO read port, data_in valid the cycle after rd_en.
REQ-013 busy, done, error: out 1 each; status.

Function
REQ-014 States IDLE, ADDR, FETCH, DATA, RESP, FINISH.
REQ-015 IDLE + start with transfer_size>0: latch addr (aligned) and ceil(transfer_size/STRB_W) beats, go ADDR; busy=1 from next cycle.
REQ-016 IDLE + start with transfer_size==0: go FINISH, no AXI or FIFO activity.
REQ-017 Burst beats = min(remaining beats, MAX_BURST, beats left to next 4 KB boundary); awlen = beats-1.
REQ-018 awsize = BYTE_SH, awburst = 2'b01 (INCR), constant while busy.
REQ-019 ADDR: awvalid=1, awaddr/awlen stable until awready; on handshake go FETCH.
REQ-020 FETCH: rd_en=1 for exactly one cycle only when empty==0; stall with rd_en=0 while empty; next cycle register data_in, go DATA.
REQ-021 DATA: wvalid=1, wdata/wstrb/wlast stable until wready; on handshake go FETCH if beats remain in burst, else RESP.
REQ-022 wlast=1 only on final beat of each burst.
REQ-023 wstrb all ones except final beat of whole transfer: low (transfer_size mod STRB_W) bits set when remainder nonzero.
REQ-024 RESP: bready=1; on bvalid with bresp==OKAY, advance address by beats*STRB_W, go ADDR if beats remain, else FINISH.
REQ-025 RESP: bvalid with bresp!=OKAY sets error=1, abandons remaining bursts, go FINISH.
REQ-026 FINISH: done=1 one cycle, busy=0, return IDLE; error holds until next accepted start, which clears it.
REQ-027 start while busy ignored; awvalid and wvalid never both high; never more than one outstanding burst.
REQ-028 Start at edge N yields awvalid high after edge N+1 (one-cycle latency).

Reset
REQ-029 rst_n low forces IDLE asynchronously; awvalid, wvalid, wlast, bready, rd_en, busy, done, error, awlen, wstrb = 0.
REQ-030 Reset mid-transfer drops all valids immediately; no resume, next start begins fresh.

Verification
REQ-031 DATA_W=32, addr=0x1000, size=8, FIFO {DEADBEEF,12345678}, ready always high -> one burst awlen=1, wdata in order, wlast on beat 2, wstrb=F,F, done pulse, error=0.
REQ-032 MAX_BURST=4, size=40 (10 beats) -> bursts awlen 3,3,1 at 0x1000,0x1010,0x1020.
REQ-033 addr=0x0FF8, size=16 -> bursts split at 4 KB: awaddr 0x0FF8 awlen 1, then 0x1000 awlen 1.
REQ-034 size=6, DATA_W=32 -> two beats, wstrb F then 3; size=0 -> done after two cycles, no awvalid.
REQ-035 empty toggled and wready/awready randomly deasserted -> rd_en never while empty, payload held stable, data order preserved.
REQ-036 bresp=SLVERR on first of three bursts -> no further awvalid, done with error=1; rst_n pulsed mid-DATA -> valids drop same cycle, busy=0.
